output_route_ctrl: RTL and testbench
====================================

# output_route_ctrl

Sequencer for the convolution-output demultiplexer. It accepts one layer's worth of result words from the convolution array over a valid/ready stream and drives the demux select. It forwards each word through a single register stage either to the main output buffer as addressed writes (fully-convolutional layer) or to the max-pooling unit as windowed groups with backpressure. It counts words, generates buffer addresses and window markers, and signals layer completion.

## Interface
- DATA_WIDTH, 32, width of result words
- ADDR_WIDTH, 10, main buffer address width
- CNT_WIDTH, 16, width of the word counters and of cfg_count
- POOL_WINDOW, 4, words per max-pooling window; power of two, ≥2
- FULLY_CONVOL, 1'b0, sel encoding for the main-buffer route
- MAX_POOLING, 1'b1, sel encoding for the max-pooling route

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches the cfg_* inputs
- cfg_mode  in  1  FULLY_CONVOL or MAX_POOLING
- cfg_count  in  CNT_WIDTH  words in the layer
- cfg_base_addr  in  ADDR_WIDTH  first main-buffer address
- busy  out  1  high from the accepted start until the done cycle, inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse when a start is rejected for bad configuration
- in_valid  in  1  upstream word valid
- in_data  in  DATA_WIDTH  upstream word
- in_ready  out  1  upstream handshake
- sel  out  1  demux select; the latched mode
- route_data  out  DATA_WIDTH  registered word driven to the demux input
- buf_we  out  1  main-buffer write strobe
- buf_addr  out  ADDR_WIDTH  main-buffer write address
- pool_valid  out  1  word valid toward max pooling
- pool_first  out  1  first word of a window; qualified by pool_valid
- pool_last  out  1  last word of a window; qualified by pool_valid
- pool_ready  in  1  max-pooling handshake

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN:** on start with a valid configuration.
  - cfg_count and cfg_base_addr are latched.
  - cfg_mode is latched into sel.
  - Both counters are cleared.
- **Bad configuration:** cfg_count == 0, or MAX_POOLING with cfg_count not a multiple of POOL_WINDOW.
  - err pulses for one cycle and the state stays IDLE.
  - sel and all other latched values are unchanged.
- **start outside IDLE:** ignored; no err.
- **Output register:** one stage, holding a valid flag and route_data.
- **Sink-ready:** always 1 in FULLY_CONVOL; equal to pool_ready in MAX_POOLING.
- **in_ready:** (state == RUN) && (accepted < count) && (!hold_valid || sink-ready).
- **Accept:** in_valid && in_ready. Loads the register and increments the accepted counter.
- **Emit:**
  - FULLY_CONVOL: every cycle the register is valid.
  - MAX_POOLING: when pool_valid && pool_ready.
  - Each emit increments the emitted counter.
  - On a same-cycle emit and accept, the new word replaces the old one, giving zero bubbles.
- **FULLY_CONVOL route:**
  - buf_we = hold_valid.
  - buf_addr = cfg_base_addr + emitted index, modulo 2^ADDR_WIDTH (wraps silently).
  - pool_valid = 0.
- **MAX_POOLING route:**
  - pool_valid = hold_valid.
  - pool_first = (emitted index mod POOL_WINDOW == 0).
  - pool_last = (emitted index mod POOL_WINDOW == POOL_WINDOW-1).
  - buf_we = 0.
  - route_data and the pool_* outputs hold stable while pool_valid && !pool_ready.
- **RUN → DONE:** on the emit of word cfg_count-1. The DONE state lasts one cycle with done = 1, then goes to IDLE.
- **After done:** sel and route_data hold their last values until the next accepted start.
- **Counter width:** counters are CNT_WIDTH wide and never exceed cfg_count.

## Timing
- **Reset values:** state IDLE; busy, done, err, in_ready, buf_we, pool_valid, pool_first, pool_last all 0; sel = FULLY_CONVOL; route_data 0; buf_addr 0.
- **Reset mid-layer:** all outputs go immediately (asynchronously) to their reset values. The partial layer is discarded.
- **Start latency:** start at cycle T means busy = 1 and in_ready may be 1 from T+1.
- **Datapath latency:** a word accepted at cycle N is presented on route_data with buf_we or pool_valid at N+1.
- **Done latency:** done asserts the cycle after the final emit. busy falls the cycle after done.
- **Throughput:** FULLY_CONVOL sustains one word per cycle. MAX_POOLING sustains one word per cycle while pool_ready = 1.
- **Strobes:** err and done are single-cycle pulses.

## Test plan
- **FULLY_CONVOL layer:** start with mode 0, count 8, base 0x100, in_valid held high, data 1..8. Required: buf_we is high for 8 consecutive cycles, with buf_addr 0x100..0x107 and route_data 1..8. done pulses once; pool_valid stays 0; sel stays 0.
- **MAX_POOLING with backpressure:** start with mode 1, count 8, and pool_ready toggling 1,0,1,0. Required: 8 pool handshakes, in order, with data held stable while stalled. pool_first is on words 0 and 4, pool_last on words 3 and 7. buf_we is never 1 and sel = 1.
- **Bad configuration:** start with count 0, then start with mode 1 and count 6. Required: err pulses each time and busy stays 0. Then start with mode 0 and count 2; it completes normally.
- **start while busy:** pulse start with different cfg values mid-layer. Required: it is ignored, and the layer finishes with the original count and base.
- **Address wrap:** base 0x3FE, count 4. Required: buf_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- **Reset mid-layer:** assert rst_n low after 3 of 8 words. Required: all outputs are at reset values immediately. A new layer with count 2 then runs cleanly with both counters starting at 0.

Source files
------------

// File: rtl/output_route_if.sv
// Bundle of the sequencer's control, upstream stream and demux-side signals.
// The master modport is the sequencer's view; the slave modport is the
// view of whatever surrounds it (array, demux, pooling unit, host).
interface output_route_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  cfg_mode;
  logic [CNT_WIDTH-1:0]  cfg_count;
  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  sel;
  logic [DATA_WIDTH-1:0] route_data;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic                  pool_valid;
  logic                  pool_first;
  logic                  pool_last;
  logic                  pool_ready;

  modport master (
    input  start, cfg_mode, cfg_count, cfg_base_addr,
    input  in_valid, in_data, pool_ready,
    output busy, done, err, in_ready,
    output sel, route_data, buf_we, buf_addr,
    output pool_valid, pool_first, pool_last
  );

  modport slave (
    output start, cfg_mode, cfg_count, cfg_base_addr,
    output in_valid, in_data, pool_ready,
    input  busy, done, err, in_ready,
    input  sel, route_data, buf_we, buf_addr,
    input  pool_valid, pool_first, pool_last
  );
endinterface

// File: rtl/output_route_ctrl.sv
// Convolution-output demux sequencer: takes one layer of result words,
// registers each one once and sends it either to the main buffer as
// addressed writes or to max pooling as windowed groups with backpressure.
module output_route_ctrl #(
  parameter int   DATA_WIDTH   = 32,
  parameter int   ADDR_WIDTH   = 10,
  parameter int   CNT_WIDTH    = 16,
  parameter int   POOL_WINDOW  = 4,
  parameter logic FULLY_CONVOL = 1'b0,
  parameter logic MAX_POOLING  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  output_route_if.master bus
);
  localparam int WIN_BITS = $clog2(POOL_WINDOW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  accepted;
  logic [CNT_WIDTH-1:0]  emitted;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  sel_q;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  err_q;
  logic                  cfg_bad;
  logic                  start_ok;
  logic                  sink_ready;
  logic                  in_ready_int;
  logic                  accept;
  logic                  emit;
  logic                  last_emit;
  logic [WIN_BITS-1:0]   win_idx;

  // A layer must contain words, and a pooled layer must fill whole windows.
  assign cfg_bad  = (bus.cfg_count == '0) ||
                    ((bus.cfg_mode == MAX_POOLING) && (bus.cfg_count[WIN_BITS-1:0] != '0));
  assign start_ok = (state == IDLE) && bus.start && !cfg_bad;

  // The main buffer never stalls; the pooling unit may.
  assign sink_ready   = (sel_q == FULLY_CONVOL) ? 1'b1 : bus.pool_ready;
  assign in_ready_int = (state == RUN) && (accepted < count_q) && (!hold_valid || sink_ready);
  assign accept       = bus.in_valid && in_ready_int;
  assign emit         = hold_valid && sink_ready;
  assign last_emit    = emit && (emitted == (count_q - CNT_WIDTH'(1)));
  assign win_idx      = emitted[WIN_BITS-1:0];

  // Next-state logic: the layer ends on the emit of its final word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (last_emit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Layer configuration is captured only on an accepted start, so a
  // rejected or ignored start leaves sel and the base/count untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      base_q  <= '0;
      sel_q   <= FULLY_CONVOL;
    end else if (start_ok) begin
      count_q <= bus.cfg_count;
      base_q  <= bus.cfg_base_addr;
      sel_q   <= bus.cfg_mode;
    end
  end

  // Word counters; both restart from zero with each new layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted <= '0;
      emitted  <= '0;
    end else if (start_ok) begin
      accepted <= '0;
      emitted  <= '0;
    end else begin
      if (accept) accepted <= accepted + CNT_WIDTH'(1);
      if (emit)   emitted  <= emitted + CNT_WIDTH'(1);
    end
  end

  // Single output stage; an accept in the same cycle as an emit refills it
  // directly so back-to-back words leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (accept)    hold_valid <= 1'b1;
      else if (emit) hold_valid <= 1'b0;
      if (accept)    hold_data  <= bus.in_data;
    end
  end

  // Rejected-start strobe, aligned with the cycle busy would have risen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state == IDLE) && bus.start && cfg_bad;
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
  assign bus.in_ready   = in_ready_int;
  assign bus.sel        = sel_q;
  assign bus.route_data = hold_data;
  assign bus.buf_we     = hold_valid && (sel_q == FULLY_CONVOL);
  assign bus.buf_addr   = base_q + ADDR_WIDTH'(emitted);
  assign bus.pool_valid = hold_valid && (sel_q == MAX_POOLING);
  assign bus.pool_first = bus.pool_valid && (win_idx == '0);
  assign bus.pool_last  = bus.pool_valid && (win_idx == WIN_BITS'(POOL_WINDOW - 1));
endmodule

// File: tb/tb_output_route_ctrl.sv
// Randomized self-checking bench for output_route_ctrl. A queue-based model
// tracks accepted-but-not-yet-delivered words and the delivery index.
module tb_output_route_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_sel = 1'b0;

  output_route_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  output_route_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .POOL_WINDOW(PW),
    .FULLY_CONVOL(1'b0), .MAX_POOLING(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    checkOutput({pfx, "_busy"},       32'(bus.busy), 32'(0));
    checkOutput({pfx, "_done"},       32'(bus.done), 32'(0));
    checkOutput({pfx, "_err"},        32'(bus.err), 32'(0));
    checkOutput({pfx, "_in_ready"},   32'(bus.in_ready), 32'(0));
    checkOutput({pfx, "_buf_we"},     32'(bus.buf_we), 32'(0));
    checkOutput({pfx, "_pool_valid"}, 32'(bus.pool_valid), 32'(0));
    checkOutput({pfx, "_pool_first"}, 32'(bus.pool_first), 32'(0));
    checkOutput({pfx, "_pool_last"},  32'(bus.pool_last), 32'(0));
    checkOutput({pfx, "_sel"},        32'(bus.sel), 32'(0));
    checkOutput({pfx, "_route_data"}, 32'(bus.route_data), 32'(0));
    checkOutput({pfx, "_buf_addr"},   32'(bus.buf_addr), 32'(0));
  endtask

  // Pulses start for one cycle; returns 1 ns after the capturing edge.
  task automatic applyStimulus(input logic mode, input int count, input int base);
    bus.cfg_mode      = mode;
    bus.cfg_count     = CW'(count);
    bus.cfg_base_addr = AW'(base);
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start         = 1'b0;
  endtask

  task automatic check_bad_cfg(input logic mode, input int count);
    applyStimulus(mode, count, 'h2A);
    checkOutput("bad_err_pulse", 32'(bus.err), 32'(1));
    checkOutput("bad_busy",      32'(bus.busy), 32'(0));
    checkOutput("bad_sel_kept",  32'(bus.sel), 32'(exp_sel));
    @(posedge clk); #1;
    checkOutput("bad_err_clear", 32'(bus.err), 32'(0));
    checkOutput("bad_busy2",     32'(bus.busy), 32'(0));
  endtask

  // Runs one layer. ready_pct < 0 toggles pool_ready 1,0,1,0...; abort_after
  // > 0 pulls reset once that many words have been delivered.
  task automatic run_layer(input logic mode, input int count, input int base,
                           input int valid_pct, input int ready_pct,
                           input bit seq_data, input int abort_after);
    logic [DW-1:0] pend[$];
    logic [DW-1:0] last_word;
    int   acc;
    int   emi;
    int   cyc;
    logic toggle;
    logic sink;
    logic exp_rdy;
    logic has;
    acc = 0; emi = 0; cyc = 0; toggle = 1'b1; last_word = '0;
    applyStimulus(mode, count, base);
    exp_sel = mode;
    while (1) begin
      bus.in_valid = ($urandom_range(99) < valid_pct);
      bus.in_data  = seq_data ? DW'(acc + 1) : DW'($urandom);
      if (ready_pct < 0) begin
        bus.pool_ready = toggle;
        toggle = ~toggle;
      end else begin
        bus.pool_ready = ($urandom_range(99) < ready_pct);
      end
      if (cyc == 2) begin
        bus.cfg_mode      = ~mode;
        bus.cfg_count     = CW'(count + 3);
        bus.cfg_base_addr = AW'(base ^ 'h155);
        bus.start         = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      has  = (pend.size() > 0);
      sink = (mode == 1'b0) ? 1'b1 : bus.pool_ready;
      checkOutput("run_busy",       32'(bus.busy), 32'(1));
      checkOutput("run_done",       32'(bus.done), 32'(0));
      checkOutput("run_err",        32'(bus.err), 32'(0));
      checkOutput("run_sel",        32'(bus.sel), 32'(mode));
      checkOutput("run_buf_we",     32'(bus.buf_we), 32'(mode == 1'b0 && has));
      checkOutput("run_pool_valid", 32'(bus.pool_valid), 32'(mode == 1'b1 && has));
      if (has) begin
        checkOutput("route_data", 32'(bus.route_data), 32'(pend[0]));
        if (mode == 1'b0) begin
          checkOutput("buf_addr", 32'(bus.buf_addr), 32'((base + emi) % (1 << AW)));
        end else begin
          checkOutput("pool_first", 32'(bus.pool_first), 32'((emi % PW) == 0));
          checkOutput("pool_last",  32'(bus.pool_last),  32'((emi % PW) == PW - 1));
        end
      end
      exp_rdy = (acc < count) && (!has || sink);
      checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (has && sink) begin
        last_word = pend.pop_front();
        emi++;
      end
      if (bus.in_valid && exp_rdy) begin
        pend.push_back(bus.in_data);
        acc++;
      end
      cyc++;
      if (emi == count) break;
      if (abort_after > 0 && emi == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_sel = 1'b0;
        return;
      end
      if (cyc > 1000) begin
        checkOutput("layer_timeout", 32'(emi), 32'(count));
        bus.start = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_pulse",    32'(bus.done), 32'(1));
    checkOutput("done_busy",     32'(bus.busy), 32'(1));
    checkOutput("done_in_ready", 32'(bus.in_ready), 32'(0));
    checkOutput("done_buf_we",   32'(bus.buf_we), 32'(0));
    checkOutput("done_pool_vld", 32'(bus.pool_valid), 32'(0));
    checkOutput("done_sel",      32'(bus.sel), 32'(mode));
    @(posedge clk); #1;
    checkOutput("post_done",     32'(bus.done), 32'(0));
    checkOutput("post_busy",     32'(bus.busy), 32'(0));
    checkOutput("post_sel_hold", 32'(bus.sel), 32'(mode));
    checkOutput("post_data_hold", 32'(bus.route_data), 32'(last_word));
  endtask

  // Directed scenarios followed by randomized layers.
  initial begin
    bus.start = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_count = '0; bus.cfg_base_addr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.pool_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] fully-convolutional layer, base 0x100");
    run_layer(1'b0, 8, 'h100, 100, 100, 1'b1, 0);
    $display("[TB] max-pooling layer with toggling pool_ready");
    run_layer(1'b1, 8, 0, 100, -1, 1'b1, 0);
    $display("[TB] bad configurations");
    check_bad_cfg(1'b0, 0);
    check_bad_cfg(1'b1, 6);
    run_layer(1'b0, 2, 'h20, 100, 100, 1'b1, 0);
    $display("[TB] address wrap");
    run_layer(1'b0, 4, 'h3FE, 100, 100, 1'b1, 0);
    $display("[TB] reset mid-layer");
    run_layer(1'b0, 8, 'h40, 100, 100, 1'b1, 3);
    run_layer(1'b0, 2, 'h50, 100, 100, 1'b1, 0);
    $display("[TB] randomized layers");
    for (int i = 0; i < 16; i++) begin
      logic m;
      int   n;
      m = 1'($urandom_range(1));
      n = m ? PW * int'($urandom_range(1, 6)) : int'($urandom_range(1, 20));
      run_layer(m, n, int'($urandom_range(1023)), 75, 60, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
